// File: rtl/conv_feature_streamer.sv
// -----------------------------------------------------------------------------
// conv_feature_streamer
//
// Raster-order feature-map feeder for the PIM convolution engine. The block
// takes one pixel per channel per accepted beat and keeps KERNEL_SIZE-1 line
// buffers per channel. For each accepted pixel it emits a KERNEL_SIZE-tall
// column slice per channel: slot 0 is the oldest row and slot KERNEL_SIZE-1 is
// the current row. A slice is flagged as completing a window once both the row
// and the column have reached KERNEL_SIZE-1.
//
// Optional build macro:
//   CONV_STREAMER_ZERO_PAD_EN  slots whose source row lies before the start
//                              of the frame read as zero. Without it they
//                              carry raw line-buffer contents, which can be
//                              previous-frame rows, or X after power-up.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   start         begin a frame (only honoured in IDLE)
//   in_valid      pixel present on in_pixel
//   in_ready      pixel accepted when in_valid && in_ready
//                 (combinational from sink_ready)
//   in_pixel      channel c at [c*BIT_WIDTH +: BIT_WIDTH]
//   sink_ready    downstream can take a slice this cycle
//   feature_out   column slice; channel c, slot k at
//                 [(c*KERNEL_SIZE+k)*BIT_WIDTH +: BIT_WIDTH]
//   en            one-cycle latch strobe, feature_out valid
//   window_valid  slice completes a full KERNEL_SIZE x KERNEL_SIZE window
//   frame_done    one-cycle end-of-frame pulse (DONE state)
//
// Handshake: a pixel transfers on a rising edge where in_valid and in_ready
// are both high. in_ready never depends on in_valid. The slice for that pixel
// is registered on the same edge and appears with en one cycle later.
// -----------------------------------------------------------------------------
module conv_feature_streamer #(
    parameter int BIT_WIDTH   = 8,
    parameter int KERNEL_SIZE = 5,
    parameter int CHANNEL     = 4,
    parameter int IMG_WIDTH   = 16,
    parameter int IMG_HEIGHT  = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [BIT_WIDTH*CHANNEL-1:0]           in_pixel,
    input  logic                                   sink_ready,
    output logic [BIT_WIDTH*KERNEL_SIZE*CHANNEL-1:0] feature_out,
    output logic                                   en,
    output logic                                   window_valid,
    output logic                                   frame_done
);

    localparam int LB_ROWS = KERNEL_SIZE - 1;
    localparam int COL_W   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int SLICE_W = BIT_WIDTH * KERNEL_SIZE * CHANNEL;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_WIN  = COL_W'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // state is kept as a named register so checkers can bind to it directly.
    state_t state;
    state_t state_next;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic accept;
    logic last_pixel;
    logic win_now;

    logic [SLICE_W-1:0]   slice_next;
    logic [BIT_WIDTH-1:0] slot;

    // Line buffers are deliberately not reset; contents survive across frames.
    logic [BIT_WIDTH-1:0] lb [CHANNEL][LB_ROWS][IMG_WIDTH];

    assign in_ready   = (state == RUN) && sink_ready;
    assign accept     = in_valid && in_ready;
    assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);
    assign win_now    = (row >= ROW_WIN) && (col >= COL_WIN);
    assign frame_done = (state == DONE);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept && last_pixel) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------- counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if ((state == IDLE) && start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ------------------------------------------------------ line buffers
    // Column x shifts up one row on every accept at x: the oldest row drops
    // out of lb[0] and the incoming pixel lands in lb[LB_ROWS-1].
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < CHANNEL; c++) begin
                for (int k = 0; k < LB_ROWS - 1; k++) begin
                    lb[c][k][col] <= lb[c][k+1][col];
                end
                lb[c][LB_ROWS-1][col] <= in_pixel[c*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    // ------------------------------------------------- slice composition
    // Slots read the pre-shift buffer values, so slot k holds row
    // (row - (KERNEL_SIZE-1) + k) of the current column.
    always_comb begin
        slice_next = '0;
        slot       = '0;
        for (int c = 0; c < CHANNEL; c++) begin
            for (int k = 0; k < LB_ROWS; k++) begin
                slot = lb[c][k][col];
`ifdef CONV_STREAMER_ZERO_PAD_EN
                // Source row precedes the frame start.
                if (int'(row) < KERNEL_SIZE - 1 - k) begin
                    slot = '0;
                end
`endif
                slice_next[(c*KERNEL_SIZE+k)*BIT_WIDTH +: BIT_WIDTH] = slot;
            end
            slice_next[(c*KERNEL_SIZE+KERNEL_SIZE-1)*BIT_WIDTH +: BIT_WIDTH] =
                in_pixel[c*BIT_WIDTH +: BIT_WIDTH];
        end
    end

    // ---------------------------------------------------- output register
    // feature_out holds its last value through cycles without an accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feature_out  <= '0;
            en           <= 1'b0;
            window_valid <= 1'b0;
        end else begin
            en           <= accept;
            window_valid <= accept && win_now;
            if (accept) begin
                feature_out <= slice_next;
            end
        end
    end

endmodule

// File: tb/tb_conv_feature_streamer.sv
// -----------------------------------------------------------------------------
// tb_conv_feature_streamer
//
// Directed bench for conv_feature_streamer at default parameters.
// Channel 0 of pixel (r, c) carries r*16 + c + base, and channel ch adds ch
// (all mod 256). A full-window slice for (r, c) therefore has
// slot k = pixel(r-4+k, c) of the same frame. The driver queues that
// expectation, and the negedge monitor pops it whenever window_valid is seen.
// -----------------------------------------------------------------------------
module tb_conv_feature_streamer;

    localparam int BW = 8;
    localparam int K  = 5;
    localparam int CH = 4;
    localparam int W  = 16;
    localparam int H  = 16;
    localparam int SW = BW * K * CH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW*CH-1:0] in_pixel = '0;
    logic          sink_ready = 1'b0;
    logic [SW-1:0] feature_out;
    logic          en;
    logic          window_valid;
    logic          frame_done;

    int checks = 0;
    int errors = 0;
    int en_count = 0;
    int win_count = 0;
    int done_count = 0;

    logic [SW-1:0] exp_q[$];

    conv_feature_streamer #(
        .BIT_WIDTH  (BW),
        .KERNEL_SIZE(K),
        .CHANNEL    (CH),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pixel    (in_pixel),
        .sink_ready  (sink_ready),
        .feature_out (feature_out),
        .en          (en),
        .window_valid(window_valid),
        .frame_done  (frame_done)
    );

    // ------------------------------------------------------ clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------ checker
    task automatic check(input string tag, input logic [SW-1:0] got,
                         input logic [SW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // -------------------------------------------------------------- model
    function automatic logic [BW-1:0] pix(input int r, input int c,
                                          input int ch, input int base);
        return BW'(r * 16 + c + ch + base);
    endfunction

    function automatic logic [BW*CH-1:0] pix_word(input int r, input int c,
                                                  input int base);
        logic [BW*CH-1:0] w;
        w = '0;
        for (int ch = 0; ch < CH; ch++) begin
            w[ch*BW +: BW] = pix(r, c, ch, base);
        end
        return w;
    endfunction

    function automatic logic [SW-1:0] exp_slice(input int r, input int c,
                                                input int base);
        logic [SW-1:0] s;
        s = '0;
        for (int ch = 0; ch < CH; ch++) begin
            for (int k = 0; k < K; k++) begin
                s[(ch*K+k)*BW +: BW] = pix(r - (K - 1) + k, c, ch, base);
            end
        end
        return s;
    endfunction

    // ---------------------------------------------------------- scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (en) en_count++;
            if (frame_done) done_count++;
            if (window_valid) begin
                win_count++;
                check("slice_expected", SW'(exp_q.size() != 0), SW'(1));
                if (exp_q.size() != 0) begin
                    check("window_slice", feature_out, exp_q.pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic start_frame();
        start = 1'b1;
        in_valid = 1'b0;
        sink_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("en_idle", SW'(en), SW'(0));
        en_count = 0;
        win_count = 0;
        done_count = 0;
    endtask

    task automatic accept_pixel(input int r, input int c, input int base);
        logic exp_wv;
        exp_wv = (r >= K - 1) && (c >= K - 1);
        in_valid = 1'b1;
        sink_ready = 1'b1;
        in_pixel = pix_word(r, c, base);
        if (exp_wv) exp_q.push_back(exp_slice(r, c, base));
        @(posedge clk); #1;
        check("en_accept", SW'(en), SW'(1));
        check("wv_accept", SW'(window_valid), SW'(exp_wv));
        in_valid = 1'b0;
    endtask

    task automatic stall(input int n, input int base);
        logic [SW-1:0] held;
        held = exp_slice(7, 8, base);
        sink_ready = 1'b0;
        in_valid = 1'b1;
        in_pixel = pix_word(7, 9, base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("bp_in_ready", SW'(in_ready), SW'(0));
            @(posedge clk); #1;
            check("bp_en", SW'(en), SW'(0));
            check("bp_wv", SW'(window_valid), SW'(0));
            check("bp_hold", feature_out, held);
        end
    endtask

    // Runs one frame; stops before pixel (abort_r, abort_c) when it is in range.
    task automatic run_frame(input int base, input logic do_bp,
                             input int abort_r, input int abort_c,
                             input logic probe);
        logic [5*BW-1:0] probe_exp;
        start_frame();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == abort_r && c == abort_c) return;
                if (do_bp && r == 7 && c == 9) stall(3, base);
                accept_pixel(r, c, base);
                if (r == 4 && c == 4 && base == 0) begin
                    check("first_window_ch0", SW'(feature_out[5*BW-1:0]),
                          SW'({8'd68, 8'd52, 8'd36, 8'd20, 8'd4}));
                end
                if (probe && r == 1 && c == 0) begin
`ifdef CONV_STREAMER_ZERO_PAD_EN
                    probe_exp = {8'd116, 8'd100, 8'd0, 8'd0, 8'd0};
`else
                    // Previous frame ended on rows 12..15; rows 13..15 remain.
                    probe_exp = {8'd116, 8'd100, 8'd240, 8'd224, 8'd208};
`endif
                    check("frame2_r1c0_ch0", SW'(feature_out[5*BW-1:0]),
                          SW'(probe_exp));
                end
            end
        end
        // One cycle after the final accept: DONE, with the final slice.
        check("frame_done_hi", SW'(frame_done), SW'(1));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("frame_done_lo", SW'(frame_done), SW'(0));
        check("en_after_frame", SW'(en), SW'(0));
        @(negedge clk);
        check("start_in_done_ignored", SW'(in_ready), SW'(0));
        check("en_count", SW'(en_count), SW'(256));
        check("win_count", SW'(win_count), SW'(144));
        check("done_count", SW'(done_count), SW'(1));
        check("queue_drained", SW'(exp_q.size()), SW'(0));
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        // Reset with every input pushing to go.
        rst = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        sink_ready = 1'b1;
        in_pixel = pix_word(3, 3, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", SW'(in_ready), SW'(0));
        check("rst_en", SW'(en), SW'(0));
        check("rst_wv", SW'(window_valid), SW'(0));
        check("rst_frame_done", SW'(frame_done), SW'(0));
        check("rst_feature_out", feature_out, '0);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", SW'(in_ready), SW'(0));
        @(posedge clk); #1;
        check("idle_in_ready_2", SW'(in_ready), SW'(0));
        check("idle_en", SW'(en), SW'(0));
        in_valid = 1'b0;

        // Frame A: full frame with a 3-cycle stall before (7,9).
        run_frame(0, 1'b1, -1, -1, 1'b0);

        // Frame B: reset arrives where pixel (2,5) would be accepted.
        run_frame(0, 1'b0, 2, 5, 1'b0);
        rst = 1'b1;
        #2;
        check("mid_rst_in_ready", SW'(in_ready), SW'(0));
        check("mid_rst_en", SW'(en), SW'(0));
        check("mid_rst_wv", SW'(window_valid), SW'(0));
        check("mid_rst_frame_done", SW'(frame_done), SW'(0));
        check("mid_rst_feature_out", feature_out, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_no_restart", SW'(in_ready), SW'(0));
        @(posedge clk); #1;

        // Frame C: fresh start after the abort, full frame.
        run_frame(0, 1'b0, -1, -1, 1'b0);

        // Frame D: back-to-back frame offset by 100, probe (1,0).
        run_frame(100, 1'b0, -1, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
